// File: rtl/sdram_resp_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : sdram_resp_pkg                                                    |
// | Brief  : Shared constants for the sdram port responder (FSM codes, counter |
// |          width, jitter LFSR polynomial and step function).                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdram_resp_pkg;

    localparam int RESP_CNT_W = 4;

    typedef logic [2:0] resp_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // x^8 + x^6 + x^5 + x^4 + 1, bit 7 is the x^8 tap
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_jitter_lfsr.sv
// +----------------------------------------------------------------------------+
// | Module : resp_jitter_lfsr                                                  |
// | Brief  : 8-bit Fibonacci LFSR producing 0..3 extra wait cycles; advances   |
// |          once per step pulse. Compiled only with SDRAM_RESP_JITTER_EN.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef SDRAM_RESP_JITTER_EN
module resp_jitter_lfsr
    import sdram_resp_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [1:0] extra
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The value in force at acceptance sets that transaction's extra wait.
    assign extra = lfsr_q[1:0];

endmodule
`endif

`default_nettype wire

// File: rtl/sdram_port_responder.sv
// +----------------------------------------------------------------------------+
// | Module : sdram_port_responder                                              |
// | Brief  : Responder side of the CPU sdram_req/sdram_write port, backed by   |
// |          an internal word RAM with fixed (or, with SDRAM_RESP_JITTER_EN,   |
// |          LFSR-jittered) latency and one-cycle ready/done pulses.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdram_port_responder
    import sdram_resp_pkg::*;
#(
    parameter int         MEM_AW    = 10,
    parameter int         RD_LAT    = 4,
    parameter int         WR_LAT    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_in,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic [31:0] sdram_data_out,
    output logic        sdram_ready,
    output logic        sdram_done
);

    // One spare bit so LAT-1 plus up to 3 jitter cycles cannot wrap.
    localparam int CNT_W = RESP_CNT_W + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic              mem_we;
    logic              accept;
    logic [1:0]        extra;
    logic [31:0]       rd_word;
    logic [31:0]       mem [2**MEM_AW];

    logic              unused_addr_bits;
    assign unused_addr_bits = ^sdram_addr[21:MEM_AW];

`ifdef SDRAM_RESP_JITTER_EN
    resp_jitter_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_jitter (
        .clk   (clk),
        .rst   (reset),
        .step  (accept),
        .extra (extra)
    );
`else
    logic [7:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign extra       = 2'b00;
`endif

    assign rd_word = mem[addr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sdram_write) begin
                    accept  = 1'b1;
                    addr_d  = sdram_addr[MEM_AW-1:0];
                    wdata_d = sdram_data_in;
                    cnt_d   = WR_LOAD + CNT_W'(extra);
                    state_d = ST_WR_WAIT;
                end else if (sdram_req) begin
                    accept  = 1'b1;
                    addr_d  = sdram_addr[MEM_AW-1:0];
                    cnt_d   = RD_LOAD + CNT_W'(extra);
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    data_out_d = rd_word;
                    ready_d    = 1'b1;
                    state_d    = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Requests stay high through ACK; wait for both to drop before re-arming.
                if (!sdram_req && !sdram_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Contents survive reset; the write is gated by state, which reset clears at once.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign sdram_data_out = data_out_q;
    assign sdram_ready    = ready_q;
    assign sdram_done     = done_q;

endmodule

`default_nettype wire
